// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: slots are reserved at issue, filled by responses in
// order, popped at the head; flush empties everything at once.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reserve_i,
  input  logic [31:0]   reserve_pc_i,
  input  logic          fill_i,
  input  logic [31:0]   fill_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic          head_vld_o,
  output logic          head_fill_o,
  output logic [31:0]   head_pc_o,
  output logic [31:0]   head_instr_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   unfilled_o
);
  fetch_entry_t slots_q [DEPTH];
  // Unfilled slots are always contiguous between fill pointer and tail.
  logic [AW:0] hd_q, fp_q, tl_q;

  assign count_o      = tl_q - hd_q;
  assign unfilled_o   = tl_q - fp_q;
  assign head_vld_o   = (count_o != '0) && slots_q[hd_q[AW-1:0]].filled;
  assign head_fill_o  = (count_o != '0) && (hd_q == fp_q);
  assign head_pc_o    = slots_q[hd_q[AW-1:0]].pc;
  assign head_instr_o = slots_q[hd_q[AW-1:0]].instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_q <= '0;
      fp_q <= '0;
      tl_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) slots_q[i] <= '0;
    end else begin
      if (reserve_i) slots_q[tl_q[AW-1:0]] <= '{pc: reserve_pc_i, instr: 32'h0, filled: 1'b0};
      if (fill_i) begin
        slots_q[fp_q[AW-1:0]].instr  <= fill_data_i;
        slots_q[fp_q[AW-1:0]].filled <= 1'b1;
      end
      if (flush_i) begin
        hd_q <= '0;
        fp_q <= '0;
        tl_q <= '0;
      end else begin
        hd_q <= hd_q + (AW+1)'(pop_i);
        fp_q <= fp_q + (AW+1)'(fill_i);
        tl_q <= tl_q + (AW+1)'(reserve_i);
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, imem handshake, stale-response dropping on redirect.
// FETCH_UNIT_BYPASS_EN: forward a response straight to instr_* when it fills the head.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [AW:0] drop_q, drop_d;
  logic        run_q;
  logic [AW:0] count, unfilled, pending;
  logic        head_vld, head_fill;
  logic [31:0] head_pc, head_instr;
  logic        issue, fill, pop;
  logic [1:0]  unused_rpc_lo;

  assign unused_rpc_lo = redirect_pc[1:0];
  assign pending       = unfilled + drop_q;

  // run_q keeps the request low until the first edge after reset release.
  assign imem_req_valid = run_q && !redirect && ((count + drop_q) < (AW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign issue          = imem_req_valid && imem_req_ready;
  assign fill           = imem_rsp_valid && (drop_q == '0) && !redirect && (unfilled != '0);
  assign pop            = instr_valid && instr_ready;

`ifdef FETCH_UNIT_BYPASS_EN
  logic byp;
  assign byp         = fill && head_fill;
  assign instr_valid = head_vld || byp;
  assign instr       = head_vld ? head_instr : (byp ? imem_rsp_data : 32'h0);
  assign instr_pc    = instr_valid ? head_pc : 32'h0;
`else
  logic unused_head_fill;
  assign unused_head_fill = head_fill;
  assign instr_valid      = head_vld;
  assign instr            = head_vld ? head_instr : 32'h0;
  assign instr_pc         = head_vld ? head_pc : 32'h0;
`endif

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (reset),
    .reserve_i    (issue),
    .reserve_pc_i (fetch_pc_q),
    .fill_i       (fill),
    .fill_data_i  (imem_rsp_data),
    .pop_i        (pop),
    .flush_i      (redirect),
    .head_vld_o   (head_vld),
    .head_fill_o  (head_fill),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .count_o      (count),
    .unfilled_o   (unfilled)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (issue) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // A response landing in the redirect cycle is itself stale.
      drop_d = pending - (AW+1)'(imem_rsp_valid && (pending != '0));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      run_q      <= 1'b1;
    end
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (drop_q != '0 || unfilled != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected {pc,instr} at issue,
// a monitor pops on every consume; a memory model answers with fixed or random latency.
module tb_fetch_unit;
  localparam int DEPTH = 4;
`ifdef FETCH_UNIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  typedef struct { logic [31:0] data; int due; } pend_t;
  exp_t  expq[$];
  pend_t pend[$];

  int total = 0, bad = 0, cyc = 0, mem_lat = 1, n_acc = 0;
  bit mem_hold = 1'b0, rand_lat = 1'b0;
  logic [31:0] exp_pc = 32'h0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: in-order responses, one per cycle, latency >= 1.
  initial begin
    int l;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (imem_rsp_valid) void'(pend.pop_front());
        if (imem_req_valid && imem_req_ready) begin
          l = rand_lat ? int'($urandom_range(1, 5)) : mem_lat;
          pend.push_back('{memw(imem_req_addr), cyc + l});
        end
      end
      @(posedge clk); #2;
      if (!reset) pend.delete();
      if (reset && !mem_hold && pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend[0].data;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Monitor: every consumed instruction must be the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (instr_valid && instr_ready) begin
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_unexpected: got pc %h instr %h, nothing expected", instr_pc, instr);
          end else begin
            e = expq.pop_front();
            chk("sb_pc", instr_pc, e.pc);
            chk("sb_instr", instr, e.ins);
          end
        end else if (!instr_valid) begin
          chk("idle_instr", instr, 32'h0);
          chk("idle_pc", instr_pc, 32'h0);
        end
      end
    end
  end

  task automatic step(input bit rr, input bit ir, input bit keep);
    @(posedge clk); #1;
    imem_req_ready = rr;
    instr_ready    = ir;
    redirect       = 1'b0;
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      if (keep) expq.push_back('{exp_pc, memw(exp_pc)});
      exp_pc += 32'd4;
      n_acc++;
    end
  endtask

  // rmode: 0 ready held, 1 random; imode: 0/1 fixed instr_ready, 2 random.
  task automatic grant(input int n, input int rmode, input int imode, input bit keep, output int steps);
    int start = n_acc;
    steps = 0;
    while (n_acc - start < n && steps < 400) begin
      step(rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b1,
           imode == 2 ? 1'($urandom_range(0, 1)) : imode[0], keep);
      steps++;
    end
    chk("grant_cnt", 32'(n_acc - start), 32'(n));
  endtask

  task automatic redir(input logic [31:0] tgt, input bit rr);
    @(posedge clk); #1;
    redirect       = 1'b1;
    redirect_pc    = tgt;
    imem_req_ready = rr;
    instr_ready    = 1'b0;
    @(negedge clk);
    chk("redir_no_req", 32'(imem_req_valid), 32'd0);
    exp_pc = {tgt[31:2], 2'b00};
  endtask

  task automatic drain();
    int b = 300;
    while ((expq.size() > 0 || pend.size() > 0) && b > 0) begin
      step(1'b0, 1'b1, 1'b0);
      b--;
    end
    chk("drain_left", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);

    // Full: consumer stalled, only DEPTH requests go out.
    @(posedge clk); #1 reset = 1'b1;
    repeat (10) step(1'b1, 1'b0, 1'b1);
    chk("full_accepts", 32'(n_acc), 32'd4);
    chk("full_req_low", 32'(imem_req_valid), 32'd0);
    grant(1, 0, 1, 1, s);
    drain();

    // Streaming at latency 1 sustains one fetch per cycle.
    grant(8, 0, 1, 1, s);
    chk("stream_steps", 32'(s), 32'd8);
    drain();

    // Redirect with 3 outstanding: all three responses are stale.
    mem_hold = 1'b1;
    grant(3, 0, 0, 0, s);
    redir(32'h0000_0103, 1'b1);
    mem_hold = 1'b0;
    grant(4, 0, 1, 1, s);
    drain();

    // A response arriving in the redirect cycle is dropped too.
    mem_hold = 1'b1;
    grant(2, 0, 0, 0, s);
    mem_hold = 1'b0;
    redir(32'h0000_0200, 1'b0);
    chk("rsp_in_redir", 32'(imem_rsp_valid), 32'd1);
    grant(2, 0, 1, 1, s);
    drain();

    // Redirect-to-instr latency with an idle queue.
    redir(32'h0000_0300, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("lat_n2_valid", 32'(instr_valid), 32'(BYP));
    step(1'b0, 1'b1, 1'b0);
    chk("lat_n3_valid", 32'(instr_valid), 32'(!BYP));
    drain();

    // Random ready and latency 1-5.
    rand_lat = 1'b1;
    grant(20, 1, 2, 1, s);
    drain();
    rand_lat = 1'b0;

    // Reset mid-stream clears everything.
    grant(3, 0, 0, 0, s);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr_pc", instr_pc, 32'h0);
    expq.delete();
    @(posedge clk); #1 reset = 1'b1;
    exp_pc = 32'h0;
    grant(2, 0, 1, 1, s);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
